// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder/subtractor built around one FullAdder_1B cell.
// Define SERIAL_ADD_SUB_EN to honour op_sub (subtract); otherwise add-only.

module FullAdder_1B (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             z_q, z_d;

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             fa_s, fa_co;
  logic             last;

`ifdef SERIAL_ADD_SUB_EN
  assign b_in = op_sub ? ~operand_b : operand_b;
  assign c_in = op_sub ? 1'b1 : carry_in;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_in = operand_b;
  assign c_in = carry_in;
`endif

  FullAdder_1B u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (cy_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      ov_q     <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      co_q     <= co_d;
      ov_q     <= ov_d;
      z_q      <= z_d;
    end
  end

  // Next-state: accept in IDLE, WIDTH bit steps in RUN, one DONE cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands, then shift one bit per edge through the cell
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    co_d     = co_q;
    ov_d     = ov_q;
    z_d      = z_q;
    if (state_q == IDLE && start) begin
      a_d   = operand_a;
      b_d   = b_in;
      acc_d = '0;
      cy_d  = c_in;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = {1'b0, a_q[WIDTH-1:1]};
      b_d   = {1'b0, b_q[WIDTH-1:1]};
      acc_d = {fa_s, acc_q[WIDTH-1:1]};
      cy_d  = fa_co;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        // cy_q here is the carry into the MSB
        result_d = acc_d;
        co_d     = fa_co;
        ov_d     = cy_q ^ fa_co;
        z_d      = ~|acc_d;
      end
    end
  end

  // Outputs decoded from state and result registers
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    result    = result_q;
    carry_out = co_q;
    overflow  = ov_q;
    zero      = z_q;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Multi-cycle controller that computes a WIDTH-bit add (and optionally subtract) by reusing a single instance of the team's 1-bit full adder cell, FullAdder_1B, one bit per clock, LSB first.
- Sits in the ALU as the area-minimal add path. It sequences operand shifting, carry feedback and flag generation, and hands the result to the CPU control unit through a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when busy=0
- op_sub  input  1  1 = operand_a - operand_b, 0 = add (see Optional Feature)
- carry_in  input  1  carry into bit 0 for add; ignored for subtract
- operand_a  input  WIDTH  first operand, captured on the accepting edge
- operand_b  input  WIDTH  second operand, captured on the accepting edge
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse: result and flags are valid and updated
- result  output  WIDTH  sum/difference; held until the next completion or reset
- carry_out  output  1  carry out of the MSB; for subtract, 1 = no borrow
- overflow  output  1  signed overflow = (carry into MSB) XOR (carry out of MSB)
- zero  output  1  1 when result == 0

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0; bit counter and shift registers cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, on that edge (E0) capture operand_a into shift register A and operand_b into shift register B. For subtract, capture ~operand_b into B. Carry register = carry_in for add, 1 for subtract. Counter = 0. Next state RUN.
  - RUN: each edge, feed A[0], B[0] and the carry register into the full adder. Shift sum into the MSB of the result shift register; shift A and B right by 1; carry register = adder carry_out; counter increments.
    - On the processing of bit WIDTH-1, also latch the carry register value (carry into MSB) for the overflow calculation.
    - After WIDTH processing edges (E1..E_WIDTH), go to DONE. On edge E_WIDTH, update result, carry_out, overflow and zero registers.
  - DONE: done=1 for exactly this one cycle. Next edge goes to IDLE unconditionally.
- Latency: done is high in the cycle after E_WIDTH, i.e. WIDTH+1 edges after the start-sampling edge. busy=1 from after E0 through the DONE cycle. Back-to-back throughput: one op per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored: no queuing, no effect on the current op.
- Operand inputs may change freely after E0; only the captured copies are used.
- Outputs result and flags change only at E_WIDTH or on reset. They are stable during the next op's RUN phase.
- Reset asserted mid-operation: abort immediately to IDLE. Partial result is discarded and all outputs are cleared per the reset rule. No done pulse.
- Widths: counter is $clog2(WIDTH+1) bits; no arithmetic wider than 1 bit outside the counter.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined: op_sub is honoured. Subtract = operand_a + ~operand_b + 1; carry_out = not-borrow; overflow per the signed rule.
- Not defined: op_sub is ignored and every op is an add with carry_in. Inverter and carry-select logic are not synthesized.

Test Plan:
- Add, WIDTH=8, a=0x3C, b=0x45, carry_in=0, start 1 cycle -> done exactly 9 edges after the accepting edge; result=0x81, carry_out=0, overflow=1, zero=0; busy high for 9 cycles.
- Add with wrap: a=0xFF, b=0x01, carry_in=0 -> result=0x00, carry_out=1, overflow=0, zero=1. Separately, a=0x00, b=0x00, carry_in=1 -> result=0x01, zero=0.
- With SERIAL_ADD_SUB_EN: a=0x05, b=0x07, op_sub=1 -> 0xFE, carry_out=0, overflow=0. Also a=0x80, b=0x01, op_sub=1 -> 0x7F, carry_out=1, overflow=1. Without the macro, a=0x05, b=0x07, op_sub=1, carry_in=0 -> 0x0C.
- Start held high continuously with changing operands during RUN -> only the first op is accepted. Next acceptance occurs on the edge after the DONE cycle. Results match operands captured at each acceptance, with no corruption from mid-op operand changes.
- Reset asserted for 1 cycle at RUN bit 4 of a=0x3C+0x45 -> next cycle busy=0, done=0, result=0, all flags 0, and no done pulse. A fresh start then yields a correct 0x81.
- Previous result 0x81 held stable through the entire RUN phase of a following op (0x01+0x01), then updates to 0x02 with a single-cycle done pulse.
